gray_pos_tracker: RTL and testbench

- Downstream consumer of the up/down gray counter output.
- Each cycle it samples a W-bit gray code and decodes it to binary.
- It classifies every transition as up, down, none or illegal, and accumulates a saturating signed position.
- A sticky error stops tracking until software clears it; the block then re-acquires a fresh reference sample.

---
 rtl/gray_pos_pkg.sv | 42 ++++
 rtl/gray_pos_tracker.sv | 203 ++++++++++++++++++++
 tb/tb_gray_pos_tracker.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/gray_pos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pos_pkg
//  Description : Shared types, step-class codes and the gray-to-binary decode
//                used by gray_pos_tracker.
//  Revision    : 1.0  initial release
// ============================================================================
package gray_pos_pkg;

    // Tracker FSM states.
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } tracker_state_t;

    // Transition classes derived from (b - prev_b) mod 2^W.
    localparam logic [1:0] NONE    = 2'd0;
    localparam logic [1:0] UP      = 2'd1;
    localparam logic [1:0] DOWN    = 2'd2;
    localparam logic [1:0] ILLEGAL = 2'd3;

    // Widest gray code the decoder handles.
    localparam int c_GRAY_MAX_W = 32;

    // Gray-to-binary decode, usable for any width W <= c_GRAY_MAX_W.
    // Each binary bit is the XOR of all gray bits at or above it, so
    // zero-extending a W-bit code leaves the low W result bits unchanged.
    // Callers zero-extend the input and truncate the result back to W.
    function automatic logic [c_GRAY_MAX_W-1:0] gray2bin(
        input logic [c_GRAY_MAX_W-1:0] g
    );
        logic [c_GRAY_MAX_W-1:0] b;
        b[c_GRAY_MAX_W-1] = g[c_GRAY_MAX_W-1];
        for (int i = c_GRAY_MAX_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_pos_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : gray_pos_tracker
//  Description : Samples a gray code every cycle, decodes it to binary,
//                classifies each transition (none/up/down/illegal) and keeps
//                a saturating signed position. An illegal transition sets a
//                sticky error that halts tracking until clr_err, after which
//                a fresh reference sample is acquired.
//  Optional    : GRAY_POS_WRAP_EN adds wrap (wrap-step pulse) and rev
//                (saturating signed 8-bit revolution count).
//  Ports       : clk      - system clock, rising edge
//                reset    - synchronous active-low reset
//                gray_in  - W-bit gray code, sampled every cycle
//                clr_err  - clears sticky error and forces re-acquisition
//                bin_out  - binary decode of last sampled gray value
//                step     - one-cycle pulse per legal single-count change
//                dir      - direction of last legal step (1 = up)
//                pos      - saturating signed position
//                wrap/rev - (optional) wrap pulse / revolution count
//                err      - sticky illegal-transition flag
//  Revision    : 1.0  initial release
// ============================================================================
module gray_pos_tracker
    import gray_pos_pkg::*;
#(
    parameter int W     = 3,
    parameter int POS_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [W-1:0]            gray_in,
    input  logic                    clr_err,
    output logic [W-1:0]            bin_out,
    output logic                    step,
    output logic                    dir,
    output logic signed [POS_W-1:0] pos,
`ifdef GRAY_POS_WRAP_EN
    output logic                    wrap,
    output logic signed [7:0]       rev,
`endif
    output logic                    err
);

    localparam logic [W-1:0]            c_ONE     = W'(1);
    localparam logic [W-1:0]            c_ALL     = '1;
    localparam logic signed [POS_W-1:0] c_POS_ONE = POS_W'(1);
    localparam logic signed [POS_W-1:0] c_POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] c_POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

    tracker_state_t r_state;
    tracker_state_t w_state_nxt;

    logic [W-1:0]            r_g_q;
    logic [W-1:0]            r_prev_b;
    logic [W-1:0]            w_b;
    logic [W-1:0]            w_d;
    logic [1:0]              w_cls;
    logic [W-1:0]            w_prev_nxt;
    logic                    w_step_nxt;
    logic                    w_dir_nxt;
    logic                    w_err_nxt;
    logic signed [POS_W-1:0] w_pos_nxt;
    logic                    w_up;
    logic                    w_dn;

    // Stage 2 decode and modular difference against the stored reference.
    assign w_b = W'(gray2bin(c_GRAY_MAX_W'(r_g_q)));
    assign w_d = w_b - r_prev_b;

    always_comb begin
        w_cls = ILLEGAL;
        if (w_d == '0) begin
            w_cls = NONE;
        end else if (w_d == c_ONE) begin
            w_cls = UP;
        end else if (w_d == c_ALL) begin
            w_cls = DOWN;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev_b;
        w_step_nxt  = 1'b0;
        w_dir_nxt   = dir;
        w_pos_nxt   = pos;
        w_err_nxt   = err;
        w_up        = 1'b0;
        w_dn        = 1'b0;
        case (r_state)
            INIT: begin
                w_prev_nxt  = w_b;
                w_state_nxt = TRACK;
            end
            TRACK: begin
                case (w_cls)
                    UP: begin
                        w_up       = 1'b1;
                        w_step_nxt = 1'b1;
                        w_dir_nxt  = 1'b1;
                        w_prev_nxt = w_b;
                        if (pos != c_POS_MAX) begin
                            w_pos_nxt = pos + c_POS_ONE;
                        end
                    end
                    DOWN: begin
                        w_dn       = 1'b1;
                        w_step_nxt = 1'b1;
                        w_dir_nxt  = 1'b0;
                        w_prev_nxt = w_b;
                        if (pos != c_POS_MIN) begin
                            w_pos_nxt = pos - c_POS_ONE;
                        end
                    end
                    ILLEGAL: begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ERR;
                    end
                    default: ;
                endcase
            end
            ERR: begin
                // Transitions are ignored here; only clr_err leaves ERR.
                if (clr_err) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = INIT;
                end
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

`ifdef GRAY_POS_WRAP_EN
    localparam logic signed [7:0] c_REV_MAX = 8'sh7F;
    localparam logic signed [7:0] c_REV_MIN = 8'sh80;
    localparam logic signed [7:0] c_REV_ONE = 8'sh01;

    logic                    w_wrap_nxt;
    logic signed [7:0]       w_rev_nxt;

    // A wrap is a legal step that lands on 0 going up or on 2^W-1 going down.
    always_comb begin
        w_wrap_nxt = 1'b0;
        w_rev_nxt  = rev;
        if (w_up && (w_b == '0)) begin
            w_wrap_nxt = 1'b1;
            if (rev != c_REV_MAX) begin
                w_rev_nxt = rev + c_REV_ONE;
            end
        end else if (w_dn && (w_b == c_ALL)) begin
            w_wrap_nxt = 1'b1;
            if (rev != c_REV_MIN) begin
                w_rev_nxt = rev - c_REV_ONE;
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sampling, reference and registered outputs. g_q is cleared on reset so
    // the first post-reset reference is a known zero rather than whatever was
    // on gray_in while reset was held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_g_q    <= '0;
            r_prev_b <= '0;
            bin_out  <= '0;
            step     <= 1'b0;
            dir      <= 1'b0;
            pos      <= '0;
            err      <= 1'b0;
`ifdef GRAY_POS_WRAP_EN
            wrap     <= 1'b0;
            rev      <= '0;
`endif
        end else begin
            r_g_q    <= gray_in;
            r_prev_b <= w_prev_nxt;
            bin_out  <= w_b;
            step     <= w_step_nxt;
            dir      <= w_dir_nxt;
            pos      <= w_pos_nxt;
            err      <= w_err_nxt;
`ifdef GRAY_POS_WRAP_EN
            wrap     <= w_wrap_nxt;
            rev      <= w_rev_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_pos_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_pos_tracker
//  Description : Self-checking bench for gray_pos_tracker. Two instances
//                (16-bit and 4-bit position) share one stimulus stream so the
//                saturation limits are exercised alongside normal tracking.
//                Expected values come from a behavioural model of the
//                tracking rules kept in this file.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_pos_tracker;

    localparam int W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [W-1:0]      gray_in;
    logic              clr_err;

    logic [W-1:0]      bin_a, bin_b;
    logic              step_a, step_b, dir_a, dir_b, err_a, err_b;
    logic signed [15:0] pos_a;
    logic signed [3:0]  pos_b;
`ifdef GRAY_POS_WRAP_EN
    logic              wrap_a, wrap_b;
    logic signed [7:0] rev_a, rev_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gray_pos_tracker #(.W(W), .POS_W(16)) u_dut_a (
        .clk     (clk),
        .reset   (reset),
        .gray_in (gray_in),
        .clr_err (clr_err),
        .bin_out (bin_a),
        .step    (step_a),
        .dir     (dir_a),
        .pos     (pos_a),
`ifdef GRAY_POS_WRAP_EN
        .wrap    (wrap_a),
        .rev     (rev_a),
`endif
        .err     (err_a)
    );

    gray_pos_tracker #(.W(W), .POS_W(4)) u_dut_b (
        .clk     (clk),
        .reset   (reset),
        .gray_in (gray_in),
        .clr_err (clr_err),
        .bin_out (bin_b),
        .step    (step_b),
        .dir     (dir_b),
        .pos     (pos_b),
`ifdef GRAY_POS_WRAP_EN
        .wrap    (wrap_b),
        .rev     (rev_b),
`endif
        .err     (err_b)
    );

    // ---------------- behavioural model ----------------
    int m_gq, m_bin, m_step, m_dir, m_err, m_pos16, m_pos4;
    int m_have_ref, m_in_err, m_ref, m_wrap, m_rev;

    function automatic int bin2gray(input int b);
        return (b ^ (b >> 1)) & 7;
    endfunction

    // Binary value is the XOR of the gray code with all its right shifts.
    function automatic int gray_decode(input int g);
        int b = 0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b & 7;
    endfunction

    task automatic model_edge(input bit r, input int g, input bit c);
        int b, d;
        b = gray_decode(m_gq);
        if (!r) begin
            m_gq = 0; m_bin = 0; m_step = 0; m_dir = 0; m_err = 0;
            m_pos16 = 0; m_pos4 = 0; m_have_ref = 0; m_in_err = 0;
            m_ref = 0; m_wrap = 0; m_rev = 0;
        end else begin
            m_bin  = b;
            m_step = 0;
            m_wrap = 0;
            if (m_in_err) begin
                if (c) begin
                    m_in_err = 0; m_err = 0; m_have_ref = 0;
                end
            end else if (!m_have_ref) begin
                m_ref = b; m_have_ref = 1;
            end else begin
                d = (b - m_ref + 8) % 8;
                if (d == 1) begin
                    m_step = 1; m_dir = 1;
                    if (m_pos16 < 32767) m_pos16++;
                    if (m_pos4 < 7) m_pos4++;
                    if (m_ref == 7 && b == 0) begin
                        m_wrap = 1;
                        if (m_rev < 127) m_rev++;
                    end
                    m_ref = b;
                end else if (d == 7) begin
                    m_step = 1; m_dir = 0;
                    if (m_pos16 > -32768) m_pos16--;
                    if (m_pos4 > -8) m_pos4--;
                    if (m_ref == 0 && b == 7) begin
                        m_wrap = 1;
                        if (m_rev > -128) m_rev--;
                    end
                    m_ref = b;
                end else if (d != 0) begin
                    m_err = 1; m_in_err = 1;
                end
            end
            m_gq = g;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_all(input string where);
        check({where, " bin_a"},  32'(bin_a),  32'(m_bin));
        check({where, " bin_b"},  32'(bin_b),  32'(m_bin));
        check({where, " step_a"}, 32'(step_a), 32'(m_step));
        check({where, " step_b"}, 32'(step_b), 32'(m_step));
        check({where, " dir_a"},  32'(dir_a),  32'(m_dir));
        check({where, " dir_b"},  32'(dir_b),  32'(m_dir));
        check({where, " err_a"},  32'(err_a),  32'(m_err));
        check({where, " err_b"},  32'(err_b),  32'(m_err));
        check({where, " pos16"},  32'(pos_a),  32'(m_pos16));
        check({where, " pos4"},   32'(pos_b),  32'(m_pos4));
`ifdef GRAY_POS_WRAP_EN
        check({where, " wrap_a"}, 32'(wrap_a), 32'(m_wrap));
        check({where, " wrap_b"}, 32'(wrap_b), 32'(m_wrap));
        check({where, " rev_a"},  32'(rev_a),  32'(m_rev));
        check({where, " rev_b"},  32'(rev_b),  32'(m_rev));
`endif
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check at the
    // following falling edge.
    task automatic tick(input string where, input bit r, input int g, input bit c);
        reset   = r;
        gray_in = W'(g);
        clr_err = c;
        @(posedge clk);
        model_edge(r, g, c);
        @(negedge clk);
        check_all(where);
    endtask

    task automatic tick_bin(input string where, input int b);
        tick(where, 1'b1, bin2gray(b), 1'b0);
    endtask

    initial begin
        int cb, sel;
        bit rr, cc;
        reset = 1'b0; gray_in = '0; clr_err = 1'b0;
        model_edge(1'b0, 0, 1'b0);

        // Reset held with a nonzero gray input.
        for (int i = 0; i < 3; i++) tick("reset", 1'b0, 3'b101, 1'b0);

        // Up sweep: 000,001,011,010,110,111,101,100,000.
        for (int i = 0; i <= 8; i++) tick_bin("up_sweep", i % 8);

        // Down: 000,100,101,111.
        tick_bin("down", 0);
        tick_bin("down", 7);
        tick_bin("down", 6);
        tick_bin("down", 5);

        // Walk back to 0, then jump to gray 011 (bin 2).
        for (int b = 4; b >= 0; b--) tick_bin("return", b);
        tick("illegal", 1'b1, 3'b011, 1'b0);
        tick("illegal", 1'b1, 3'b011, 1'b0);
        tick("illegal_in_err", 1'b1, 3'b000, 1'b0);
        tick("clr_err", 1'b1, 3'b011, 1'b1);
        tick("reacq", 1'b1, 3'b011, 1'b0);
        tick("reacq", 1'b1, 3'b010, 1'b0);
        tick("reacq", 1'b1, 3'b010, 1'b0);

        // Saturation: many ups, one down, then many downs.
        cb = 3;
        for (int i = 0; i < 12; i++) begin cb = (cb + 1) % 8; tick_bin("sat_up", cb); end
        cb = (cb + 7) % 8; tick_bin("sat_down1", cb);
        for (int i = 0; i < 24; i++) begin cb = (cb + 7) % 8; tick_bin("sat_down", cb); end
        tick_bin("sat_hold", cb);

        // Mid-operation reset with pos=5 and err=1.
        tick("midrst_pre", 1'b0, 0, 1'b0);
        for (int b = 0; b <= 5; b++) tick_bin("midrst_up", b);
        tick_bin("midrst_up", 5);
        tick_bin("midrst_bad", 1);
        tick_bin("midrst_bad", 1);
        tick("midrst_bad", 1'b1, bin2gray(1), 1'b1);
        tick_bin("midrst_bad", 4);
        tick_bin("midrst_bad", 6);
        tick("midrst", 1'b0, bin2gray(6), 1'b0);
        tick_bin("midrst_post", 0);
        tick_bin("midrst_post", 0);
        tick_bin("midrst_post", 1);

        // Randomised walk with occasional jumps, clears and resets.
        cb = 1;
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 45)      cb = (cb + 1) % 8;
            else if (sel < 78) cb = (cb + 7) % 8;
            else if (sel < 92) cb = cb;
            else               cb = int'($urandom_range(0, 7));
            cc = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 99) != 0);
            tick("random", rr, bin2gray(cb), cc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
